wide_alu_seq: RTL and testbench
===============================

# wide_alu_seq

Multi-cycle sequencer that runs an N-byte ADD, SUB, shift-left or shift-right on the shared 8-bit ALU, one byte per clock, by chaining the ALU's shift/carry bit between bytes. It sits between the control unit and the ALU instance. It owns the ALU's command, operand and carry-in inputs while an operation runs. It returns a registered wide result with aggregated carry, zero and parity flags.

## Interface
- NBYTES, default 4: operand width in bytes (≥2); W = 8·NBYTES.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  2  00 ADD, 01 SUB, 10 SHL by 1, 11 SHR by 1.
- a  in  W  operand A; captured at accept.
- b  in  W  operand B; captured at accept; ignored for shifts.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  W  registered result.
- carry  out  1  final carry-out / shifted-out bit.
- zero  out  1  result == 0.
- parity  out  1  XOR of all result bits.
- alu_cmd  out  3  to ALU: 000 add, 001 left shift, 010 right shift.
- alu_a  out  8  to ALU inA.
- alu_b  out  8  to ALU inB.
- alu_sc_i  out  1  to ALU shift/carry in.
- alu_rslt  in  8  from ALU.
- alu_sc_o  in  1  from ALU shift/carry out.
- alu_zero  in  1  from ALU zero flag.
- alu_pari  in  1  from ALU parity flag.

## Operation
- States: IDLE, RUN, DONE. Byte counter idx runs 0..NBYTES-1. Operands, op, chain carry and the flag accumulators are held in registers.
- Accept: start=1 while in IDLE or DONE. The block latches a, b and op, clears the accumulators, sets idx=0 and moves to RUN. start is ignored in RUN.
- ADD: alu_cmd=000, alu_b=B byte, sc chain starts at 0. Bytes run from LSB to MSB.
- SUB: alu_cmd=000, alu_b=~B byte, sc chain starts at 1, which computes A+~B+1. carry=1 means no borrow (A≥B unsigned).
- SHL: alu_cmd=001, sc chain starts at 0. Bytes run from LSB to MSB. carry is the old bit W-1.
- SHR: alu_cmd=010. Bytes run from MSB to LSB. The initial sc_i is 0 (see Configuration). carry is the old bit 0.
- Each RUN cycle:
  - alu_a/alu_b/alu_sc_i are driven combinationally from the current byte and the chain register.
  - On the edge, alu_rslt is written into byte idx of result and alu_sc_o into the chain register.
  - zero_acc &= alu_zero; par_acc ^= alu_pari.
- After byte NBYTES-1, the block moves to DONE. carry = last alu_sc_o, zero = zero_acc, parity = par_acc.
- DONE lasts one cycle, then the block returns to IDLE unless a new start is accepted.
- Outside RUN: alu_cmd=000, alu_a=0, alu_b=0, alu_sc_i=0.
- result and flags hold their values until the next accepted start. During RUN they are partial and must not be used.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, carry 0, zero 1, parity 0, chain 0, idx 0.
- If start is sampled at edge E0, RUN covers edges E1..E_NBYTES. busy is high from after E0 through E_NBYTES.
- done is high for exactly the one cycle after edge E_NBYTES. Latency from accept to done is NBYTES+1 edges.
- Back-to-back: start sampled in the DONE cycle is accepted. busy rises at the next edge, so throughput is one operation per NBYTES+1 cycles.
- Reset mid-RUN aborts immediately. All outputs take their reset values asynchronously, and no done is produced.
- Arithmetic is unsigned, modulo 2^W. Overflow is reported only through carry.

## Configuration
- WIDE_ALU_SEQ_ASR_EN:
  - Defined: SHR is arithmetic. The initial alu_sc_i for the MSB byte is the old bit W-1, so the sign is replicated.
  - Undefined: SHR is logical, with the initial alu_sc_i at 0.
  - All other ops are identical in both builds.

## Test plan
- NBYTES=4, ADD a=0x000000FF, b=0x00000001 → result 0x00000100, carry 0, zero 0, parity 1; done exactly 5 edges after accept, for one cycle.
- ADD a=0xFFFFFFFF, b=0x00000001 → result 0x00000000, carry 1, zero 1, parity 0.
- SUB a=5, b=7 → result 0xFFFFFFFE, carry 0. SUB a=7, b=5 → result 0x00000002, carry 1.
- SHL a=0x80000001 → result 0x00000002, carry 1. SHR a=0x80000001 → result 0x40000000, carry 1 without the macro; 0xC0000000 with WIDE_ALU_SEQ_ASR_EN.
- Pulse start in RUN with different operands → ignored, first result intact. Pulse start in the DONE cycle → accepted, second done 5 edges later.
- Assert rst_n=0 during RUN byte 2 → busy 0, done 0, result 0, zero 1 immediately; no done after release.

Source files
------------

// File: rtl/wide_alu_seq.sv
// Multi-cycle N-byte ADD/SUB/SHL/SHR sequencer driving a shared 8-bit ALU, one byte per clock.
// Optional build macro WIDE_ALU_SEQ_ASR_EN makes SHR arithmetic (sign-replicating) instead of logical.
module wide_alu_seq #(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         parity,
    output logic [2:0]   alu_cmd,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic         alu_sc_i,
    input  logic [7:0]   alu_rslt,
    input  logic         alu_sc_o,
    input  logic         alu_zero,
    input  logic         alu_pari
);

    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_SHL = 2'b10, OP_SHR = 2'b11} op_e;

    state_e             state_q;
    op_e                op_q;
    logic [W-1:0]       a_q, b_q, result_q;
    logic [IDX_W-1:0]   idx_q;
    logic               chain_q, zero_q, parity_q;

    logic [IDX_W-1:0]   byte_sel;
    logic [7:0]         a_byte, b_byte;
    logic               shr_fill, chain_init;

`ifdef WIDE_ALU_SEQ_ASR_EN
    assign shr_fill = a[W-1];
`else
    assign shr_fill = 1'b0;
`endif

    // SUB seeds the chain with 1 so the adder computes A + ~B + 1.
    always_comb begin
        chain_init = 1'b0;
        case (op_e'(op))
            OP_SUB:  chain_init = 1'b1;
            OP_SHR:  chain_init = shr_fill;
            default: chain_init = 1'b0;
        endcase
    end

    // SHR walks MSB to LSB; everything else walks LSB to MSB.
    assign byte_sel = (op_q == OP_SHR) ? (LAST_IDX - idx_q) : idx_q;
    assign a_byte   = a_q[8*int'(byte_sel) +: 8];
    assign b_byte   = b_q[8*int'(byte_sel) +: 8];

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_cmd  = 3'b000;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_sc_i = 1'b0;
        if (state_q == S_RUN) begin
            alu_a    = a_byte;
            alu_sc_i = chain_q;
            case (op_q)
                OP_ADD: alu_b = b_byte;
                OP_SUB: alu_b = ~b_byte;
                OP_SHL: alu_cmd = 3'b001;
                OP_SHR: alu_cmd = 3'b010;
                default: alu_cmd = 3'b000;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            chain_q  <= 1'b0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op_e'(op);
                        idx_q    <= '0;
                        chain_q  <= chain_init;
                        zero_q   <= 1'b1;
                        parity_q <= 1'b0;
                        state_q  <= S_RUN;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    result_q[8*int'(byte_sel) +: 8] <= alu_rslt;
                    chain_q  <= alu_sc_o;
                    zero_q   <= zero_q & alu_zero;
                    parity_q <= parity_q ^ alu_pari;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The chain register ends each operation holding the final carry / shifted-out bit.
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign carry  = chain_q;
    assign zero   = zero_q;
    assign parity = parity_q;

endmodule

// File: tb/tb_wide_alu_seq.sv
// Self-checking bench for wide_alu_seq (NBYTES=4) with a behavioural 8-bit ALU model.
// Honours WIDE_ALU_SEQ_ASR_EN for the SHR expectation.
module tb_wide_alu_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, carry, zero, parity;
    logic [W-1:0] result;
    logic [2:0]   alu_cmd;
    logic [7:0]   alu_a, alu_b, alu_rslt;
    logic         alu_sc_i, alu_sc_o, alu_zero, alu_pari;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wide_alu_seq #(.NBYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero), .parity(parity),
        .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_sc_i(alu_sc_i),
        .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o), .alu_zero(alu_zero), .alu_pari(alu_pari)
    );

    // Shared 8-bit ALU: add with carry, shift left/right through the sc bit.
    logic [8:0] sum9;
    always_comb begin
        sum9     = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_sc_i};
        alu_rslt = 8'h00;
        alu_sc_o = 1'b0;
        case (alu_cmd)
            3'b000: begin alu_rslt = sum9[7:0];              alu_sc_o = sum9[8];  end
            3'b001: begin alu_rslt = {alu_a[6:0], alu_sc_i}; alu_sc_o = alu_a[7]; end
            3'b010: begin alu_rslt = {alu_sc_i, alu_a[7:1]}; alu_sc_o = alu_a[0]; end
            default: begin alu_rslt = 8'h00;                 alu_sc_o = 1'b0;     end
        endcase
        alu_zero = (alu_rslt == 8'h00);
        alu_pari = ^alu_rslt;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents a request at the falling edge; returns just after the accepting edge E0.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges (E0 counted as 1) until done is seen, with a bounded budget.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] res;
        logic         c, z, p;
    } vec_t;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, SHL = 2'b10, SHR = 2'b11;

    vec_t vecs[11];
    int   n;
    logic saw_done;

    initial begin
        vecs[0]  = '{"add_ff_1",    ADD, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{"add_wrap",    ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{"sub_5_7",     SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{"sub_7_5",     SUB, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{"shl_8001",    SHL, 32'h8000_0001, 32'hDEAD_BEEF, 32'h0000_0002, 1'b1, 1'b0, 1'b1};
`ifdef WIDE_ALU_SEQ_ASR_EN
        vecs[5]  = '{"shr_8001",    SHR, 32'h8000_0001, 32'hDEAD_BEEF, 32'hC000_0000, 1'b1, 1'b0, 1'b0};
`else
        vecs[5]  = '{"shr_8001",    SHR, 32'h8000_0001, 32'hDEAD_BEEF, 32'h4000_0000, 1'b1, 1'b0, 1'b1};
`endif
        vecs[6]  = '{"add_mixed",   ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"sub_0_0",     SUB, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{"shr_1",       SHR, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{"shl_7fff",    SHL, 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{"add_msb",     ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        #12;
        check("rst_busy",   W'(busy),    W'(1'b0));
        check("rst_done",   W'(done),    W'(1'b0));
        check("rst_result", result,      '0);
        check("rst_carry",  W'(carry),   W'(1'b0));
        check("rst_zero",   W'(zero),    W'(1'b1));
        check("rst_parity", W'(parity),  W'(1'b0));
        check("rst_alucmd", W'(alu_cmd), W'(3'b000));
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_busy"}, W'(busy), W'(1'b1));
            wait_done(1, n);
            check({vecs[i].name, "_lat"},    W'(n),         W'(NB + 1));
            check({vecs[i].name, "_result"}, result,        vecs[i].res);
            check({vecs[i].name, "_carry"},  W'(carry),     W'(vecs[i].c));
            check({vecs[i].name, "_zero"},   W'(zero),      W'(vecs[i].z));
            check({vecs[i].name, "_parity"}, W'(parity),    W'(vecs[i].p));
            @(posedge clk); #1;
            check({vecs[i].name, "_pulse"},  W'(done),      W'(1'b0));
            check({vecs[i].name, "_idle"},   W'({alu_cmd, alu_a, alu_b, alu_sc_i}), '0);
        end

        // start pulsed during RUN must be ignored
        issue(ADD, 32'h0000_00FF, 32'h0000_0001);
        @(negedge clk);
        start = 1'b1; op = SUB; a = 32'h0000_0007; b = 32'h0000_0005;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, n);
        check("ign_lat",    W'(n),     W'(NB + 1));
        check("ign_result", result,    32'h0000_0100);
        check("ign_carry",  W'(carry), W'(1'b0));

        // start in the DONE cycle is accepted back-to-back
        start = 1'b1; op = SUB; a = 32'h0000_0007; b = 32'h0000_0005;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy",   W'(busy),  W'(1'b1));
        check("b2b_done",   W'(done),  W'(1'b0));
        wait_done(1, n);
        check("b2b_lat",    W'(n),     W'(NB + 1));
        check("b2b_result", result,    32'h0000_0002);
        check("b2b_carry",  W'(carry), W'(1'b1));

        // reset during RUN byte 2 aborts immediately
        issue(ADD, 32'h0101_0101, 32'h0101_0101);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy",   W'(busy),  W'(1'b0));
        check("abort_done",   W'(done),  W'(1'b0));
        check("abort_result", result,    '0);
        check("abort_zero",   W'(zero),  W'(1'b1));
        check("abort_carry",  W'(carry), W'(1'b0));
        @(negedge clk); rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_nodone", W'(saw_done), W'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
